// File: rtl/noc_output_arbiter_if.sv
// Output-link bundle between the input FIFOs, the output arbiter and the downstream link.
//   in_empty_i  : per-FIFO empty flags          (environment -> arbiter)
//   in_data_i   : per-FIFO registered read data (environment -> arbiter), slice i = FIFO i
//   credit_i    : one-cycle credit return pulse (downstream  -> arbiter)
//   in_rd_en_o  : per-FIFO read enable, at most one hot (arbiter -> FIFOs)
//   out_data_o  : flit to downstream                    (arbiter -> link)
//   out_wr_en_o : downstream write strobe               (arbiter -> link)
//   grant_o     : one-hot locked input, zero when idle
//   busy_o      : arbiter is locked onto a packet
// Modport master is the arbiter side; modport slave is the FIFO/link side.
interface noc_output_arbiter_if #(
  parameter int unsigned IN_N   = 5,
  parameter int unsigned DATA_W = 8
);
  logic [IN_N-1:0]        in_empty_i;
  logic [IN_N*DATA_W-1:0] in_data_i;
  logic                   credit_i;
  logic [IN_N-1:0]        in_rd_en_o;
  logic [DATA_W-1:0]      out_data_o;
  logic                   out_wr_en_o;
  logic [IN_N-1:0]        grant_o;
  logic                   busy_o;

  modport master (
    input  in_empty_i, in_data_i, credit_i,
    output in_rd_en_o, out_data_o, out_wr_en_o, grant_o, busy_o
  );

  modport slave (
    output in_empty_i, in_data_i, credit_i,
    input  in_rd_en_o, out_data_o, out_wr_en_o, grant_o, busy_o
  );
endinterface

// File: rtl/noc_output_arbiter.sv
// Round-robin wormhole arbiter sharing one router output link among IN_N input FIFOs.
// Locks onto an input from HEAD to TAIL, reads one flit per cycle while downstream
// credits remain, and forwards the granted FIFO's registered read data one cycle later.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset; all outputs are 0 while low
//   bus_io  : arbiter side of noc_output_arbiter_if (FIFO read port, link write port,
//             credit return, grant/busy status)
module noc_output_arbiter #(
  parameter int unsigned IN_N    = 5,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CREDITS = 3,
  parameter int unsigned CNT_W   = $clog2(CREDITS + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  noc_output_arbiter_if.master bus_io
);

  localparam int unsigned IdxW = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam logic [CNT_W-1:0] CredMax = CNT_W'(CREDITS);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q, state_d;
  logic [IN_N-1:0]   gnt_q, gnt_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic              rd_v_q, rd_v_d;
  logic [CNT_W-1:0]  cred_q, cred_d;

  logic [IN_N-1:0]   req;
  logic [IN_N-1:0]   rd_en;
  logic              rd_any;
  logic              can_rd;
  logic              found;
  logic [IdxW-1:0]   pick;
  logic [IdxW-1:0]   idx;
  logic [IdxW-1:0]   gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic              tail_seen;

  assign req    = ~bus_io.in_empty_i;
  assign can_rd = (cred_q != '0);

  // First requester found scanning rr_ptr_q, rr_ptr_q+1, ... modulo IN_N.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned k = 0; k < IN_N; k++) begin
      idx = IdxW'((32'(rr_ptr_q) + k) % IN_N);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Granted slice and its index; data is zero when nothing is granted.
  always_comb begin
    gnt_data = '0;
    gnt_idx  = '0;
    for (int unsigned i = 0; i < IN_N; i++) begin
      if (gnt_q[i]) begin
        gnt_data = bus_io.in_data_i[i*DATA_W +: DATA_W];
        gnt_idx  = IdxW'(i);
      end
    end
  end

  // TAIL (01) and SINGLE (11) are exactly the types with the low type bit set.
  assign tail_seen = rd_v_q & gnt_data[DATA_W-2];

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    rd_v_d   = 1'b0;
    rd_en    = '0;
    unique case (state_q)
      StIdle: begin
        if (found && can_rd) begin
          rd_en[pick] = 1'b1;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          state_d     = StLocked;
          rd_v_d      = 1'b1;
        end
      end
      StLocked: begin
        if (tail_seen) begin
          state_d  = StIdle;
          gnt_d    = '0;
          rr_ptr_d = (gnt_idx == IdxW'(IN_N - 1)) ? '0 : gnt_idx + 1'b1;
        end else begin
          // Lock is held while the source is empty or credits are exhausted.
          rd_en  = gnt_q & req & {IN_N{can_rd}};
          rd_v_d = |rd_en;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read enables are combinational from in_empty_i, so gate them off during reset.
  assign bus_io.in_rd_en_o = rd_en & {IN_N{rst_ni}};
  assign rd_any            = |bus_io.in_rd_en_o;

  // A credit is reserved at read time; returns beyond CREDITS are dropped.
  always_comb begin
    cred_d = cred_q;
    if (rd_any && !bus_io.credit_i) begin
      cred_d = cred_q - 1'b1;
    end else if (!rd_any && bus_io.credit_i && (cred_q != CredMax)) begin
      cred_d = cred_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      rd_v_q   <= 1'b0;
      cred_q   <= CredMax;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      rd_v_q   <= rd_v_d;
      cred_q   <= cred_d;
    end
  end

  assign bus_io.out_data_o  = gnt_data;
  assign bus_io.out_wr_en_o = rd_v_q;
  assign bus_io.grant_o     = gnt_q;
  assign bus_io.busy_o      = (state_q == StLocked);

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: directed scenarios with per-cycle tables,
// plus randomized packet loads checked against a packet-level round-robin model.
module tb_noc_output_arbiter;

  localparam int IN_N    = 5;
  localparam int DATA_W  = 8;
  localparam int CREDITS = 3;

  localparam logic [1:0] TyHead   = 2'b10;
  localparam logic [1:0] TyBody   = 2'b00;
  localparam logic [1:0] TyTail   = 2'b01;
  localparam logic [1:0] TySingle = 2'b11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  noc_output_arbiter_if #(.IN_N(IN_N), .DATA_W(DATA_W)) bus ();

  noc_output_arbiter #(
    .IN_N   (IN_N),
    .DATA_W (DATA_W),
    .CREDITS(CREDITS)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DATA_W-1:0] fq [IN_N][$];
  logic [DATA_W-1:0] out_log [$];
  int                down_occ = 0;
  bit                auto_credit = 1'b0;
  bit                last_wr = 1'b0;
  int                tag = 0;

  logic [IN_N-1:0]   s_rd, s_gnt;
  logic              s_wr, s_busy;
  logic [DATA_W-1:0] s_data;

  function automatic logic [DATA_W-1:0] flit(input logic [1:0] ty, input int id);
    logic [5:0] t;
    t = id[5:0];
    return {ty, t};
  endfunction

  task automatic push(input int i, input logic [DATA_W-1:0] f);
    fq[i].push_back(f);
    bus.in_empty_i[i] = 1'b0;
  endtask

  task automatic push_pkt(input int i, input int len);
    if (len == 1) begin
      push(i, flit(TySingle, tag)); tag++;
    end else begin
      push(i, flit(TyHead, tag)); tag++;
      for (int j = 0; j < len - 2; j++) begin
        push(i, flit(TyBody, tag)); tag++;
      end
      push(i, flit(TyTail, tag)); tag++;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < IN_N; i++) fq[i].delete();
    bus.in_empty_i = '1;
    bus.in_data_i  = '0;
  endtask

  // One clock cycle, entered and left at a falling edge. Samples outputs 1 time unit
  // after entry, models the FIFOs' registered read and the downstream occupancy.
  task automatic clk_cycle(input bit cred);
    bus.credit_i = auto_credit ? last_wr : cred;
    if (bus.credit_i && down_occ > 0) down_occ--;
    #1;
    s_rd   = bus.in_rd_en_o;
    s_wr   = bus.out_wr_en_o;
    s_data = bus.out_data_o;
    s_gnt  = bus.grant_o;
    s_busy = bus.busy_o;
    n_cmp++;
    if ($countones(s_rd) > 1) begin
      n_fail++;
      $display("FAIL rd_onehot: in_rd_en_o=%b, required at most one bit set", s_rd);
    end
    for (int i = 0; i < IN_N; i++) begin
      if (s_rd[i]) begin
        n_cmp++;
        if (fq[i].size() == 0) begin
          n_fail++;
          $display("FAIL rd_of_empty: read issued to empty FIFO %0d", i);
        end
      end
    end
    if (s_wr) begin
      out_log.push_back(s_data);
      down_occ++;
      n_cmp++;
      if (down_occ > CREDITS) begin
        n_fail++;
        $display("FAIL credit_overflow: downstream occupancy %0d, required <= %0d",
                 down_occ, CREDITS);
      end
    end
    last_wr = s_wr;
    @(posedge clk);
    #1;
    for (int i = 0; i < IN_N; i++) begin
      if (s_rd[i] && fq[i].size() != 0) bus.in_data_i[i*DATA_W +: DATA_W] = fq[i].pop_front();
      bus.in_empty_i[i] = (fq[i].size() == 0);
    end
    bus.credit_i = 1'b0;
    @(negedge clk);
  endtask

  // Return credits until the arbiter is idle with nothing in flight.
  task automatic drain();
    bit done;
    done = 1'b0;
    auto_credit = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      clk_cycle(down_occ > 0);
      if (down_occ == 0 && !s_busy && !s_wr && s_rd == '0) done = 1'b1;
      for (int i = 0; i < IN_N; i++) if (fq[i].size() != 0) done = 1'b0;
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: busy=%b occupancy=%0d, required idle and 0", s_busy, down_occ);
    end
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.credit_i   = 1'b0;
    flush();
    #3;
    push(2, flit(TySingle, 0));
    #1;
    n_cmp++; if (bus.in_rd_en_o !== '0) begin n_fail++;
      $display("FAIL reset_rd: got %b want 0", bus.in_rd_en_o); end
    n_cmp++; if (bus.out_wr_en_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_wr: got %b want 0", bus.out_wr_en_o); end
    n_cmp++; if (bus.out_data_o !== '0) begin n_fail++;
      $display("FAIL reset_data: got %h want 0", bus.out_data_o); end
    n_cmp++; if (bus.grant_o !== '0) begin n_fail++;
      $display("FAIL reset_grant: got %b want 0", bus.grant_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    @(negedge clk);
    flush();
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.grant_o !== '0 || bus.busy_o !== 1'b0) begin n_fail++;
      $display("FAIL reset_release: grant=%b busy=%b want 0/0", bus.grant_o, bus.busy_o); end
    @(negedge clk);
  endtask

  task automatic test_single_packet();
    logic [IN_N-1:0]   e_rd [5];
    logic              e_wr [5];
    logic [IN_N-1:0]   e_gnt [5];
    logic [DATA_W-1:0] e_data [5];
    e_rd   = '{5'b00010, 5'b00010, 5'b00010, 5'b00000, 5'b00000};
    e_wr   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    e_gnt  = '{5'b00000, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
    e_data = '{8'h00, flit(TyHead, 1), flit(TyBody, 2), flit(TyTail, 3), 8'h00};
    auto_credit = 1'b0;
    push(1, flit(TyHead, 1));
    push(1, flit(TyBody, 2));
    push(1, flit(TyTail, 3));
    for (int c = 0; c < 5; c++) begin
      clk_cycle(1'b0);
      n_cmp++; if (s_rd !== e_rd[c]) begin n_fail++;
        $display("FAIL single_rd[%0d]: got %b want %b", c, s_rd, e_rd[c]); end
      n_cmp++; if (s_wr !== e_wr[c]) begin n_fail++;
        $display("FAIL single_wr[%0d]: got %b want %b", c, s_wr, e_wr[c]); end
      n_cmp++; if (s_gnt !== e_gnt[c]) begin n_fail++;
        $display("FAIL single_grant[%0d]: got %b want %b", c, s_gnt, e_gnt[c]); end
      n_cmp++; if (s_data !== e_data[c]) begin n_fail++;
        $display("FAIL single_data[%0d]: got %h want %h", c, s_data, e_data[c]); end
    end
    drain();
  endtask

  // Pointer sits at 2 after the single packet, so FIFO2 goes first.
  task automatic test_round_robin();
    logic [DATA_W-1:0] exp_d [8];
    logic [IN_N-1:0]   exp_g [8];
    logic [IN_N-1:0]   e_rd, e_gnt;
    for (int k = 0; k < 4; k++) begin
      push(0, flit(TySingle, 20 + k));
      push(2, flit(TySingle, 30 + k));
      exp_d[2*k]     = flit(TySingle, 30 + k);
      exp_g[2*k]     = 5'b00100;
      exp_d[2*k + 1] = flit(TySingle, 20 + k);
      exp_g[2*k + 1] = 5'b00001;
    end
    auto_credit = 1'b1;
    for (int c = 0; c < 17; c++) begin
      clk_cycle(1'b0);
      e_rd  = (c % 2 == 0 && c < 16) ? exp_g[c/2] : '0;
      e_gnt = (c % 2 == 1) ? exp_g[c/2] : '0;
      n_cmp++; if (s_rd !== e_rd) begin n_fail++;
        $display("FAIL rr_rd[%0d]: got %b want %b", c, s_rd, e_rd); end
      n_cmp++; if (s_gnt !== e_gnt) begin n_fail++;
        $display("FAIL rr_grant[%0d]: got %b want %b", c, s_gnt, e_gnt); end
      n_cmp++; if (s_wr !== (c % 2 == 1)) begin n_fail++;
        $display("FAIL rr_wr[%0d]: got %b want %b", c, s_wr, (c % 2 == 1)); end
      if (c % 2 == 1) begin
        n_cmp++; if (s_data !== exp_d[c/2]) begin n_fail++;
          $display("FAIL rr_data[%0d]: got %h want %h", c, s_data, exp_d[c/2]); end
      end
    end
    drain();
  endtask

  task automatic test_wormhole();
    logic [IN_N-1:0]   e_rd [11];
    logic              e_wr [11];
    logic [IN_N-1:0]   e_gnt [11];
    logic [DATA_W-1:0] e_data [11];
    e_rd  = '{5'b01000, 0, 0, 0, 0, 5'b01000, 5'b01000, 0, 5'b00001, 0, 0};
    e_wr  = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0};
    e_gnt = '{0, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000, 5'b01000,
              0, 5'b00001, 0};
    e_data = '{0, flit(TyHead, 40), 0, 0, 0, 0, flit(TyBody, 42), flit(TyTail, 43), 0,
               flit(TySingle, 41), 0};
    auto_credit = 1'b1;
    push(3, flit(TyHead, 40));
    for (int c = 0; c < 11; c++) begin
      if (c == 2) push(0, flit(TySingle, 41));
      if (c == 5) begin
        push(3, flit(TyBody, 42));
        push(3, flit(TyTail, 43));
      end
      clk_cycle(1'b0);
      n_cmp++; if (s_rd !== e_rd[c]) begin n_fail++;
        $display("FAIL worm_rd[%0d]: got %b want %b", c, s_rd, e_rd[c]); end
      n_cmp++; if (s_wr !== e_wr[c]) begin n_fail++;
        $display("FAIL worm_wr[%0d]: got %b want %b", c, s_wr, e_wr[c]); end
      n_cmp++; if (s_gnt !== e_gnt[c]) begin n_fail++;
        $display("FAIL worm_grant[%0d]: got %b want %b", c, s_gnt, e_gnt[c]); end
      if (e_wr[c]) begin
        n_cmp++; if (s_data !== e_data[c]) begin n_fail++;
          $display("FAIL worm_data[%0d]: got %h want %h", c, s_data, e_data[c]); end
      end
    end
    drain();
  endtask

  // Pointer is at 1 here: FIFO1 carries the 5-flit packet, FIFO2 the follow-up packet.
  task automatic test_credit_stall();
    logic [IN_N-1:0] e_rd [14];
    logic            e_wr [14];
    bit              e_cr [14];
    e_rd = '{5'b00010, 5'b00010, 5'b00010, 0, 0, 0, 5'b00010, 0, 0, 5'b00010, 0,
             5'b00100, 0, 0};
    e_wr = '{0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0};
    e_cr = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    auto_credit = 1'b0;
    tag = 50;
    push_pkt(1, 5);
    for (int c = 0; c < 14; c++) begin
      if (c == 11) push_pkt(2, 3);
      clk_cycle(e_cr[c]);
      n_cmp++; if (s_rd !== e_rd[c]) begin n_fail++;
        $display("FAIL stall_rd[%0d]: got %b want %b", c, s_rd, e_rd[c]); end
      n_cmp++; if (s_wr !== e_wr[c]) begin n_fail++;
        $display("FAIL stall_wr[%0d]: got %b want %b", c, s_wr, e_wr[c]); end
    end
    drain();
  endtask

  task automatic test_credit_saturation();
    int n_rd, n_wr;
    auto_credit = 1'b0;
    clk_cycle(1'b1);
    clk_cycle(1'b1);
    tag = 60;
    push_pkt(4, 5);
    n_rd = 0;
    n_wr = 0;
    for (int c = 0; c < 8; c++) begin
      clk_cycle(1'b0);
      if (s_rd != '0) n_rd++;
      if (s_wr) n_wr++;
      n_cmp++; if ((s_rd != '0) !== (c < 3)) begin n_fail++;
        $display("FAIL sat_rd[%0d]: got %b want read=%0d", c, s_rd, (c < 3)); end
    end
    n_cmp++; if (n_rd != 3) begin n_fail++;
      $display("FAIL sat_reads: got %0d want 3", n_rd); end
    n_cmp++; if (n_wr != 3) begin n_fail++;
      $display("FAIL sat_writes: got %0d want 3", n_wr); end
    drain();
  endtask

  task automatic test_reset_mid_packet();
    logic [IN_N-1:0] e_rd [5];
    logic [IN_N-1:0] e_gnt [5];
    logic            e_wr [5];
    e_rd  = '{5'b00010, 5'b00010, 5'b00010, 0, 0};
    e_gnt = '{0, 5'b00010, 5'b00010, 5'b00010, 5'b00010};
    e_wr  = '{0, 1, 1, 1, 0};
    auto_credit = 1'b1;
    tag = 70;
    push_pkt(2, 4);
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    #2;
    n_cmp++; if (bus.out_wr_en_o !== 1'b1 || bus.out_data_o !== flit(TyBody, 71)) begin
      n_fail++;
      $display("FAIL midpkt_pre: wr=%b data=%h want 1/%h", bus.out_wr_en_o, bus.out_data_o,
               flit(TyBody, 71));
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.in_rd_en_o !== '0) begin n_fail++;
      $display("FAIL midpkt_rd: got %b want 0", bus.in_rd_en_o); end
    n_cmp++; if (bus.out_wr_en_o !== 1'b0) begin n_fail++;
      $display("FAIL midpkt_wr: got %b want 0", bus.out_wr_en_o); end
    n_cmp++; if (bus.out_data_o !== '0) begin n_fail++;
      $display("FAIL midpkt_data: got %h want 0", bus.out_data_o); end
    n_cmp++; if (bus.grant_o !== '0) begin n_fail++;
      $display("FAIL midpkt_grant: got %b want 0", bus.grant_o); end
    n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++;
      $display("FAIL midpkt_busy: got %b want 0", bus.busy_o); end
    flush();
    down_occ = 0;
    last_wr  = 1'b0;
    push(3, flit(TySingle, 80));
    tag = 81;
    push_pkt(1, 5);
    #1;
    n_cmp++; if (bus.in_rd_en_o !== '0) begin n_fail++;
      $display("FAIL midpkt_hold_rd: got %b want 0", bus.in_rd_en_o); end
    @(negedge clk);
    rst_n = 1'b1;
    auto_credit = 1'b0;
    for (int c = 0; c < 5; c++) begin
      clk_cycle(1'b0);
      n_cmp++; if (s_rd !== e_rd[c]) begin n_fail++;
        $display("FAIL postrst_rd[%0d]: got %b want %b", c, s_rd, e_rd[c]); end
      n_cmp++; if (s_gnt !== e_gnt[c]) begin n_fail++;
        $display("FAIL postrst_grant[%0d]: got %b want %b", c, s_gnt, e_gnt[c]); end
      n_cmp++; if (s_wr !== e_wr[c]) begin n_fail++;
        $display("FAIL postrst_wr[%0d]: got %b want %b", c, s_wr, e_wr[c]); end
    end
    drain();
  endtask

  // Preloaded random packets; expected output order comes from a packet-level
  // round-robin over FIFOs that still hold packets, pointer starting at 0.
  task automatic test_random();
    logic [DATA_W-1:0] mq [IN_N][$];
    int                pk_len [IN_N][$];
    logic [DATA_W-1:0] exp_q [$];
    int                ptr, w, len, npk;
    bit                any, reached;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      flush();
      down_occ = 0;
      last_wr  = 1'b0;
      out_log.delete();
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < IN_N; i++) begin
        mq[i].delete();
        pk_len[i].delete();
        npk = $urandom_range(0, 3);
        for (int p = 0; p < npk; p++) begin
          len = $urandom_range(1, 4);
          pk_len[i].push_back(len);
          push_pkt(i, len);
          for (int j = fq[i].size() - len; j < fq[i].size(); j++) mq[i].push_back(fq[i][j]);
        end
      end
      ptr = 0;
      any = 1'b1;
      while (any) begin
        any = 1'b0;
        for (int k = 0; k < IN_N && !any; k++) begin
          w = (ptr + k) % IN_N;
          if (pk_len[w].size() != 0) begin
            any = 1'b1;
            len = pk_len[w].pop_front();
            for (int j = 0; j < len; j++) exp_q.push_back(mq[w].pop_front());
            ptr = (w + 1) % IN_N;
          end
        end
      end
      auto_credit = 1'b0;
      reached = (exp_q.size() == 0);
      for (int c = 0; c < 600 && !reached; c++) begin
        clk_cycle((down_occ > 0) && ($urandom_range(0, 1) == 1));
        if (out_log.size() >= exp_q.size()) reached = 1'b1;
      end
      drain();
      n_cmp++; if (out_log.size() != exp_q.size()) begin n_fail++;
        $display("FAIL rand%0d_count: got %0d flits want %0d", r, out_log.size(), exp_q.size());
      end
      for (int j = 0; j < exp_q.size() && j < out_log.size(); j++) begin
        n_cmp++; if (out_log[j] !== exp_q[j]) begin n_fail++;
          $display("FAIL rand%0d_flit[%0d]: got %h want %h", r, j, out_log[j], exp_q[j]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_wormhole();
    test_credit_stall();
    test_credit_saturation();
    test_reset_mid_packet();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
